tower_spawn_scheduler: RTL and testbench

- Game-flow controller for the falling-tower object.
- Sequences the run/pause/freeze/game-over flow and ramps difficulty by level.
- Drives the tower mover's spawnX, curTreeCount and pause inputs.
- Sits between the game-control inputs (keys, player/tower collision) and the tower mover.

---
 rtl/tower_game_pkg.sv | 15 +
 rtl/spawn_lfsr11.sv | 28 ++
 rtl/tower_spawn_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_tower_spawn_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tower_game_pkg.sv
// Shared constants and the scheduler state encoding for the falling-tower game.
package tower_game_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int TOWER_W  = 28;
  localparam int TOWER_H  = 58;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PAUSED    = 3'd2,
    FREEZE    = 3'd3,
    GAME_OVER = 3'd4
  } sched_state_t;
endpackage

// File: rtl/spawn_lfsr11.sv
// 11-bit Fibonacci LFSR (x^11 + x^9 + 1, period 2047); steps once per clk while en is high.
module spawn_lfsr11 #(
  parameter logic [10:0] SEED = 11'h5A5
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        en,
  output logic [10:0] state,
  output logic [10:0] step_value
);
  logic [10:0] lfsr_q;
  logic [10:0] lfsr_d;
  logic [10:0] lfsr_step;

  // step_value is the value the register takes on the next enabled edge.
  always_comb begin
    lfsr_step = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
    lfsr_d    = en ? lfsr_step : lfsr_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign state      = lfsr_q;
  assign step_value = lfsr_step;
endmodule

// File: rtl/tower_spawn_scheduler.sv
// Game-flow scheduler for the falling tower: run/pause/game-over sequencing, level ramp and
// spawn X. Define TOWER_SCHED_HITFREEZE_EN to add the post-hit FREEZE state.
module tower_spawn_scheduler
  import tower_game_pkg::*;
#(
  parameter int          LEVEL_FRAMES  = 600,
  parameter int          BASE_TREES    = 1,
  parameter int          MAX_TREES     = 15,
  parameter int          MAX_LEVEL     = 7,
  parameter int          START_LIVES   = 3,
`ifdef TOWER_SCHED_HITFREEZE_EN
  parameter int          FREEZE_FRAMES = 60,
`endif
  parameter int          SPAWN_X_MAX   = SCREEN_W - TOWER_W,
  parameter logic [10:0] LFSR_SEED     = 11'h5A5
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startGame,
  input  logic               pauseReq,
  input  logic               playerHit,
  output logic signed [10:0] spawnX,
  output logic [3:0]         curTreeCount,
  output logic               pause,
  output logic [2:0]         level,
  output logic [1:0]         lives,
  output logic               gameOver,
  output sched_state_t       state_dbg
);
  localparam int FRAME_W = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(LEVEL_FRAMES - 1);
  localparam logic [2:0]         LEVEL_TOP  = 3'(MAX_LEVEL);
  localparam logic [1:0]         LIVES_INIT = 2'(START_LIVES);
  localparam logic [3:0]         TREES_BASE = 4'(BASE_TREES);
  localparam logic [3:0]         TREES_MAX  = 4'(MAX_TREES);
  localparam logic [9:0]         SPAWN_LIM  = 10'(SPAWN_X_MAX);
`ifdef TOWER_SCHED_HITFREEZE_EN
  localparam int               FRZ_W    = $clog2(FREEZE_FRAMES + 1);
  localparam logic [FRZ_W-1:0] FRZ_INIT = FRZ_W'(FREEZE_FRAMES);
`endif

  function automatic logic [3:0] tree_count(input logic [2:0] lvl);
    logic [4:0] sum;
    sum = {1'b0, TREES_BASE} + {2'b00, lvl};
    return (sum > {1'b0, TREES_MAX}) ? TREES_MAX : sum[3:0];
  endfunction

  sched_state_t        state_q, state_d;
  logic [2:0]          level_q, level_d;
  logic [1:0]          lives_q, lives_d;
  logic [3:0]          tree_q, tree_d;
  logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [10:0]         spawn_x_q, spawn_x_d;
  logic                pause_q, pause_d;
  logic                game_over_q, game_over_d;
`ifdef TOWER_SCHED_HITFREEZE_EN
  logic [FRZ_W-1:0]    freeze_cnt_q, freeze_cnt_d;
`endif
  logic                frame_apply;
  logic [10:0]         lfsr_state;
  logic [10:0]         lfsr_step;
  logic                unused_lfsr;

  spawn_lfsr11 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk        (clk),
    .resetN     (resetN),
    .en         (frame_apply),
    .state      (lfsr_state),
    .step_value (lfsr_step)
  );

  assign unused_lfsr = ^{lfsr_state, lfsr_step[10]};

  // Event priority: startGame, playerHit, pauseReq, then frame bookkeeping.
  // A frame is only counted when the cycle ends in RUN and no hit was taken.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;
    spawn_x_d   = spawn_x_q;
    frame_apply = 1'b0;
`ifdef TOWER_SCHED_HITFREEZE_EN
    freeze_cnt_d = freeze_cnt_q;
`endif
    if (startGame) begin
      state_d     = RUN;
      level_d     = '0;
      lives_d     = LIVES_INIT;
      frame_cnt_d = '0;
      frame_apply = startOfFrame;
    end else begin
      case (state_q)
        RUN: begin
          if (playerHit) begin
            if (lives_q <= 2'd1) begin
              lives_d = '0;
              state_d = GAME_OVER;
            end else begin
              lives_d = lives_q - 2'd1;
`ifdef TOWER_SCHED_HITFREEZE_EN
              state_d      = FREEZE;
              freeze_cnt_d = FRZ_INIT;
`endif
            end
          end else if (pauseReq) begin
            state_d = PAUSED;
          end else begin
            frame_apply = startOfFrame;
          end
        end
        PAUSED: begin
          if (pauseReq) begin
            state_d     = RUN;
            frame_apply = startOfFrame;
          end
        end
`ifdef TOWER_SCHED_HITFREEZE_EN
        FREEZE: begin
          if (startOfFrame) begin
            if (freeze_cnt_q <= FRZ_W'(1)) begin
              freeze_cnt_d = '0;
              state_d      = RUN;
            end else begin
              freeze_cnt_d = freeze_cnt_q - FRZ_W'(1);
            end
          end
        end
`endif
        default: ;
      endcase
    end

    if (frame_apply) begin
      spawn_x_d = {1'b0, (lfsr_step[9:0] >= SPAWN_LIM) ? (lfsr_step[9:0] - SPAWN_LIM)
                                                        : lfsr_step[9:0]};
      if (frame_cnt_d == LAST_FRAME) begin
        frame_cnt_d = '0;
        if (level_d != LEVEL_TOP) level_d = level_d + 3'd1;
      end else begin
        frame_cnt_d = frame_cnt_d + FRAME_W'(1);
      end
    end

    tree_d      = tree_count(level_d);
    pause_d     = (state_d != RUN);
    game_over_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      level_q      <= '0;
      lives_q      <= LIVES_INIT;
      tree_q       <= TREES_BASE;
      frame_cnt_q  <= '0;
      spawn_x_q    <= '0;
      pause_q      <= 1'b1;
      game_over_q  <= 1'b0;
`ifdef TOWER_SCHED_HITFREEZE_EN
      freeze_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      tree_q       <= tree_d;
      frame_cnt_q  <= frame_cnt_d;
      spawn_x_q    <= spawn_x_d;
      pause_q      <= pause_d;
      game_over_q  <= game_over_d;
`ifdef TOWER_SCHED_HITFREEZE_EN
      freeze_cnt_q <= freeze_cnt_d;
`endif
    end
  end

  assign spawnX       = spawn_x_q;
  assign curTreeCount = tree_q;
  assign pause        = pause_q;
  assign level        = level_q;
  assign lives        = lives_q;
  assign gameOver     = game_over_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_tower_spawn_scheduler.sv
// Self-checking bench for tower_spawn_scheduler: vector table plus multi-cycle sequences.
module tb_tower_spawn_scheduler;
  import tower_game_pkg::*;

  localparam int W = 25;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               startGame = 1'b0;
  logic               pauseReq = 1'b0;
  logic               playerHit = 1'b0;
  logic signed [10:0] spawnX;
  logic [3:0]         curTreeCount;
  logic               pause;
  logic [2:0]         level;
  logic [1:0]         lives;
  logic               gameOver;
  sched_state_t       state_dbg;

  tower_spawn_scheduler dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .startGame    (startGame),
    .pauseReq     (pauseReq),
    .playerHit    (playerHit),
    .spawnX       (spawnX),
    .curTreeCount (curTreeCount),
    .pause        (pause),
    .level        (level),
    .lives        (lives),
    .gameOver     (gameOver),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  // Scoreboard and reference model state
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  sched_state_t e_st = IDLE;
  logic [2:0]   e_lvl = 3'd0;
  logic [1:0]   e_lives = 2'd3;
  logic [10:0]  e_spawn = 11'd0;
  logic [10:0]  m_lfsr = 11'h5A5;
  int           m_total = 0;
  int           range_bad = 0;

  typedef struct {
    logic         sg, pr, ph, sof;
    sched_state_t st;
    logic [1:0]   lv;
    logic         frm;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [3:0] exp_tree(input logic [2:0] l);
    int t;
    t = 1 + int'(l);
    return 4'((t > 15) ? 15 : t);
  endfunction

  function automatic logic [W-1:0] pack_exp(input sched_state_t st, input logic [2:0] lvl,
                                            input logic [1:0] lv, input logic [10:0] sp);
    return {st, (st != RUN), (st == GAME_OVER), lvl, lv, exp_tree(lvl), sp};
  endfunction

  task automatic model_frame();
    logic [9:0] v;
    int l;
    m_lfsr = {m_lfsr[9:0], m_lfsr[10] ^ m_lfsr[8]};
    v = m_lfsr[9:0];
    e_spawn = {1'b0, (v >= 10'd612) ? (v - 10'd612) : v};
    m_total = m_total + 1;
    l = m_total / 600;
    e_lvl = 3'((l > 7) ? 7 : l);
  endtask

  task automatic model_restart();
    e_st = RUN;
    e_lvl = 3'd0;
    e_lives = 2'd3;
    m_total = 0;
  endtask

  task automatic check_out(input string name);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    act_v = {state_dbg, pause, gameOver, level, lives, curTreeCount, spawnX};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, act_v);
      return;
    end
    exp_v = exp_q.pop_front();
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got st=%0d pause=%0b go=%0b lvl=%0d lives=%0d trees=%0d spawnX=%0d, want st=%0d pause=%0b go=%0b lvl=%0d lives=%0d trees=%0d spawnX=%0d",
               name, act_v[24:22], act_v[21], act_v[20], act_v[19:17], act_v[16:15], act_v[14:11], act_v[10:0],
               exp_v[24:22], exp_v[21], exp_v[20], exp_v[19:17], exp_v[16:15], exp_v[14:11], exp_v[10:0]);
    end
  endtask

  // Drive one cycle of event pulses; expectation is queued as the stimulus goes out.
  task automatic apply(input logic sg, input logic pr, input logic ph, input logic sof,
                       input string name);
    exp_q.push_back(pack_exp(e_st, e_lvl, e_lives, e_spawn));
    startGame = sg;
    pauseReq = pr;
    playerHit = ph;
    startOfFrame = sof;
    @(posedge clk);
    #1;
    startGame = 1'b0;
    pauseReq = 1'b0;
    playerHit = 1'b0;
    startOfFrame = 1'b0;
    check_out(name);
  endtask

  task automatic set_vec(input int i, input logic sg, input logic pr, input logic ph,
                         input logic sof, input sched_state_t st, input logic [1:0] lv,
                         input logic frm);
    tbl[i].sg = sg; tbl[i].pr = pr; tbl[i].ph = ph; tbl[i].sof = sof;
    tbl[i].st = st; tbl[i].lv = lv; tbl[i].frm = frm;
  endtask

  initial begin
    set_vec(0,  1'b1, 1'b0, 1'b0, 1'b0, RUN,    2'd3, 1'b0);
    set_vec(1,  1'b0, 1'b1, 1'b0, 1'b0, PAUSED, 2'd3, 1'b0);
    set_vec(2,  1'b0, 1'b0, 1'b0, 1'b1, PAUSED, 2'd3, 1'b0);
    set_vec(3,  1'b0, 1'b0, 1'b1, 1'b0, PAUSED, 2'd3, 1'b0);
    set_vec(4,  1'b0, 1'b1, 1'b0, 1'b1, RUN,    2'd3, 1'b1);
`ifdef TOWER_SCHED_HITFREEZE_EN
    set_vec(5,  1'b0, 1'b1, 1'b1, 1'b1, FREEZE, 2'd2, 1'b0);
    set_vec(6,  1'b0, 1'b1, 1'b0, 1'b0, FREEZE, 2'd2, 1'b0);
    set_vec(7,  1'b0, 1'b0, 1'b1, 1'b0, FREEZE, 2'd2, 1'b0);
    set_vec(9,  1'b0, 1'b0, 1'b1, 1'b0, FREEZE, 2'd2, 1'b0);
`else
    set_vec(5,  1'b0, 1'b1, 1'b1, 1'b1, RUN,    2'd2, 1'b0);
    set_vec(6,  1'b0, 1'b1, 1'b0, 1'b0, PAUSED, 2'd2, 1'b0);
    set_vec(7,  1'b0, 1'b0, 1'b1, 1'b0, PAUSED, 2'd2, 1'b0);
    set_vec(9,  1'b0, 1'b0, 1'b1, 1'b0, RUN,    2'd2, 1'b0);
`endif
    set_vec(8,  1'b1, 1'b0, 1'b0, 1'b1, RUN,    2'd3, 1'b1);
    set_vec(10, 1'b1, 1'b0, 1'b1, 1'b0, RUN,    2'd3, 1'b0);
    set_vec(11, 1'b0, 1'b0, 1'b0, 1'b1, RUN,    2'd3, 1'b1);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(pack_exp(IDLE, 3'd0, 2'd3, 11'd0));
    check_out("reset_state");
    @(negedge clk);
    resetN = 1'b1;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].sg) m_total = 0;
      if (tbl[i].frm) model_frame();
      e_st = tbl[i].st;
      e_lives = tbl[i].lv;
      apply(tbl[i].sg, tbl[i].pr, tbl[i].ph, tbl[i].sof, $sformatf("vec[%0d]", i));
    end

    // Level ramp over 6000 frames with a 10-frame pause just before the first level step
    model_restart();
    apply(1'b1, 1'b0, 1'b0, 1'b0, "ramp_start");
    for (int k = 1; k <= 6000; k++) begin
      if (k == 596) begin
        e_st = PAUSED;
        apply(1'b0, 1'b1, 1'b0, 1'b0, "pause_enter");
        for (int p = 0; p < 10; p++) apply(1'b0, 1'b0, 1'b0, 1'b1, "paused_frame");
        e_st = RUN;
        apply(1'b0, 1'b1, 1'b0, 1'b0, "pause_exit");
      end
      model_frame();
      apply(1'b0, 1'b0, 1'b0, 1'b1, $sformatf("ramp_frame_%0d", k));
      if (spawnX < 0 || spawnX > 611) range_bad++;
    end

    // Hits leading to game over, then restart
    model_restart();
    apply(1'b1, 1'b0, 1'b0, 1'b0, "restart_after_ramp");
`ifdef TOWER_SCHED_HITFREEZE_EN
    for (int h = 0; h < 2; h++) begin
      e_lives = e_lives - 2'd1;
      e_st = FREEZE;
      apply(1'b0, 1'b0, 1'b1, 1'b0, "hit_to_freeze");
      for (int f = 1; f <= 60; f++) begin
        if (f == 30) begin
          apply(1'b0, 1'b0, 1'b1, 1'b0, "hit_in_freeze");
          apply(1'b0, 1'b1, 1'b0, 1'b0, "pause_in_freeze");
        end
        if (f == 60) e_st = RUN;
        apply(1'b0, 1'b0, 1'b0, 1'b1, $sformatf("freeze_frame_%0d", f));
      end
    end
`else
    for (int h = 0; h < 2; h++) begin
      e_lives = e_lives - 2'd1;
      apply(1'b0, 1'b0, 1'b1, 1'b0, "hit_stays_run");
      model_frame();
      apply(1'b0, 1'b0, 1'b0, 1'b1, "frame_after_hit");
    end
`endif
    e_lives = 2'd0;
    e_st = GAME_OVER;
    apply(1'b0, 1'b0, 1'b1, 1'b0, "fatal_hit");
    apply(1'b0, 1'b0, 1'b0, 1'b1, "go_ignore_sof");
    apply(1'b0, 1'b1, 1'b0, 1'b0, "go_ignore_pause");
    apply(1'b0, 1'b0, 1'b1, 1'b0, "go_ignore_hit");
    model_restart();
    apply(1'b1, 1'b0, 1'b0, 1'b0, "go_restart");

    // Asynchronous reset between clock edges
`ifdef TOWER_SCHED_HITFREEZE_EN
    e_lives = 2'd2;
    e_st = FREEZE;
    apply(1'b0, 1'b0, 1'b1, 1'b0, "hit_before_reset");
`else
    model_frame();
    apply(1'b0, 1'b0, 1'b0, 1'b1, "frame_before_reset");
`endif
    #2;
    resetN = 1'b0;
    #1;
    e_st = IDLE;
    e_lvl = 3'd0;
    e_lives = 2'd3;
    e_spawn = 11'd0;
    m_lfsr = 11'h5A5;
    m_total = 0;
    exp_q.push_back(pack_exp(e_st, e_lvl, e_lives, e_spawn));
    check_out("async_reset");
    @(negedge clk);
    resetN = 1'b1;
    model_restart();
    apply(1'b1, 1'b0, 1'b0, 1'b0, "post_reset_start");
    model_frame();
    apply(1'b0, 1'b0, 1'b0, 1'b1, "post_reset_frame");

    checks++;
    if (range_bad != 0) begin
      errors++;
      $display("FAIL spawn_range: %0d frames outside 0..611, want 0", range_bad);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
